// File: rtl/vga_text_pkg.sv
// Shared types and helpers for the VGA character buffer.
// Engine state encoding, default fill code, RAM address sizing.
package vga_text_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SCROLL
  } state_t;

  localparam logic [7:0] FILL_CHAR_DEF = 8'h20;

  function automatic int addr_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/vga_text_dpram.sv
// Simple dual-port RAM: one sync write port, one sync read-first read port.
// Storage is left unreset so it maps onto block RAM.
module vga_text_dpram #(
  parameter int DEPTH = 4800,
  parameter int WIDTH = 8,
  parameter int AW    = 13
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/vga_text_buffer.sv
// Scrollable character grid with clear/scroll engine and registered read port.
// Logical rows map onto physical rows through a rotating scroll base.
module vga_text_buffer
  import vga_text_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int CHAR_W = 8,
  parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(FILL_CHAR_DEF),
  parameter int ROW_W  = 7,
  parameter int COL_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [CHAR_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic              clear_req,
  input  logic              scroll_req,
  output logic              busy,
  output logic [ROW_W-1:0]  scroll_base
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = addr_w(ROWS, COLS);

  localparam logic [AW-1:0]    LP_COLS     = AW'(COLS);
  localparam logic [AW-1:0]    LP_LAST_CLR = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    LP_LAST_SCR = AW'(COLS - 1);
  localparam logic [ROW_W:0]   LP_ROWS     = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0]   LP_COLS_C   = (COL_W + 1)'(COLS);
  localparam logic [ROW_W-1:0] LP_ROW_LAST = ROW_W'(ROWS - 1);

  state_t              r_state;
  state_t              w_nxt_state;
  logic [AW-1:0]       r_cnt;
  logic [ROW_W-1:0]    r_base;
  logic [ROW_W-1:0]    r_blank_row;
  logic                r_rd_oor;

  logic                w_rd_ok;
  logic                w_wr_ok;
  logic [AW-1:0]       w_rd_addr;
  logic [AW-1:0]       w_wr_addr;
  logic [AW-1:0]       w_eng_addr;
  logic                w_ram_we;
  logic [AW-1:0]       w_ram_waddr;
  logic [CHAR_W-1:0]   w_ram_wdata;
  logic [CHAR_W-1:0]   w_ram_q;

  function automatic logic f_in_range(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    return ({1'b0, row} < LP_ROWS) && ({1'b0, col} < LP_COLS_C);
  endfunction

  // Both operands are below ROWS, so one conditional subtract wraps.
  function automatic logic [ROW_W-1:0] f_phys(
    input logic [ROW_W-1:0] row,
    input logic [ROW_W-1:0] base
  );
    logic [ROW_W:0] sum;
    sum = {1'b0, row} + {1'b0, base};
    if (sum >= LP_ROWS) begin
      return ROW_W'(sum - LP_ROWS);
    end
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [AW-1:0] f_addr(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    return AW'(row) * LP_COLS + AW'(col);
  endfunction

  always_comb begin
    w_rd_ok   = f_in_range(rd_row, rd_col);
    w_wr_ok   = f_in_range(wr_row, wr_col);
    w_rd_addr = f_addr(f_phys(rd_row, r_base), rd_col);
    w_wr_addr = f_addr(f_phys(wr_row, r_base), wr_col);
    if (r_state == CLEAR) begin
      w_eng_addr = r_cnt;
    end else begin
      w_eng_addr = f_addr(r_blank_row, COL_W'(r_cnt));
    end
  end

  always_comb begin
    w_ram_we    = 1'b1;
    w_ram_waddr = w_eng_addr;
    w_ram_wdata = FILL_CHAR;
    unique case (1'b1)
      (r_state == IDLE): begin
        w_ram_we    = wr_valid && w_wr_ok;
        w_ram_waddr = w_wr_addr;
        w_ram_wdata = wr_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      CLEAR: begin
        if (r_cnt == LP_LAST_CLR) w_nxt_state = IDLE;
      end
      SCROLL: begin
        if (r_cnt == LP_LAST_SCR) w_nxt_state = IDLE;
      end
      IDLE: begin
        if (clear_req) begin
          w_nxt_state = CLEAR;
        end else if (scroll_req) begin
          w_nxt_state = SCROLL;
        end
      end
      default: w_nxt_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != w_nxt_state) begin
      r_cnt <= '0;
    end else if (r_state != IDLE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The old base row becomes the new bottom logical row, so it gets blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_blank_row <= '0;
    end else if (r_state == IDLE) begin
      if (clear_req) begin
        r_base <= '0;
      end else if (scroll_req) begin
        r_blank_row <= r_base;
        r_base      <= (r_base == LP_ROW_LAST) ? '0 : r_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_oor <= 1'b1;
    end else begin
      r_rd_oor <= !w_rd_ok;
    end
  end

  vga_text_dpram #(
    .DEPTH (DEPTH),
    .WIDTH (CHAR_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

  assign rd_data     = r_rd_oor ? FILL_CHAR : w_ram_q;
  assign wr_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign scroll_base = r_base;

endmodule

// File: tb/tb_vga_text_buffer.sv
// Bench for vga_text_buffer: read scoreboard plus directed engine checks.
// Inputs change on the falling edge; reads are checked 1 ns after the rising edge.
module tb_vga_text_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] rd_row, rd_col, wr_row, wr_col;
  logic [7:0] rd_data, wr_data;
  logic       wr_valid, wr_ready, clear_req, scroll_req, busy;
  logic [6:0] scroll_base;
  logic       rd_issue;

  typedef struct {
    int         row;
    int         col;
    logic [7:0] exp;
  } rd_t;

  rd_t sb_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  vga_text_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_data     (rd_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .clear_req   (clear_req),
    .scroll_req  (scroll_req),
    .busy        (busy),
    .scroll_base (scroll_base)
  );

  initial begin
    rd_t e;
    forever begin
      @(posedge clk);
      if (rd_issue) begin
        #1;
        n_chk++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow rd_data=%h with no expected entry", rd_data);
        end else begin
          e = sb_q.pop_front();
          if (rd_data !== e.exp) begin
            n_fail++;
            $display("FAIL rd(%0d,%0d) got %h expected %h",
                     e.row, e.col, rd_data, e.exp);
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic rd(input int r, input int c, input logic [7:0] exp);
    rd_t e;
    rd_row = 7'(r);
    rd_col = 7'(c);
    rd_issue = 1'b1;
    e.row = r;
    e.col = c;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic wr(input int r, input int c, input logic [7:0] d,
                    output int waits);
    wr_row = 7'(r);
    wr_col = 7'(c);
    wr_data = d;
    wr_valid = 1'b1;
    waits = 0;
    while (!wr_ready && waits < 6000) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 6000) chk("wr_ready_timeout", 0, 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic count_busy(input int scroll_at, output int n);
    n = 0;
    while (busy && n < 10000) begin
      n++;
      if (n == scroll_at) scroll_req = 1'b1;
      @(negedge clk);
      scroll_req = 1'b0;
    end
  endtask

  task automatic pulse(input logic clr, input logic scr);
    clear_req = clr;
    scroll_req = scr;
    @(negedge clk);
    clear_req = 1'b0;
    scroll_req = 1'b0;
  endtask

  task automatic sweep_blank();
    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++)
        rd(r, c, 8'h20);
  endtask

  initial begin
    int n;
    int w;
    rst_n = 1'b0;
    rd_row = '0; rd_col = '0;
    wr_row = '0; wr_col = '0; wr_data = '0;
    wr_valid = 1'b0; clear_req = 1'b0; scroll_req = 1'b0;
    rd_issue = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rd_data", int'(rd_data), 8'h20);
    chk("reset_busy", int'(busy), 1);
    chk("reset_wr_ready", int'(wr_ready), 0);
    chk("reset_scroll_base", int'(scroll_base), 0);

    rst_n = 1'b1;
    count_busy(0, n);
    chk("init_clear_cycles", n, 4800);
    chk("init_wr_ready", int'(wr_ready), 1);
    chk("init_scroll_base", int'(scroll_base), 0);
    sweep_blank();

    wr(0, 0, 8'h41, w);
    wr(59, 79, 8'h5A, w);
    wr(60, 0, 8'h77, w);
    wr(0, 80, 8'h77, w);
    rd(0, 0, 8'h41);
    rd(59, 79, 8'h5A);
    rd(60, 0, 8'h20);
    rd(0, 80, 8'h20);
    rd(1, 0, 8'h20);
    rd(127, 127, 8'h20);

    wr_row = 7'd1; wr_col = 7'd1; wr_data = 8'h55; wr_valid = 1'b1;
    rd(1, 1, 8'h20);
    wr_valid = 1'b0;
    rd(1, 1, 8'h55);

    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++)
        wr(r, c, 8'(r + 8'h30), w);
    pulse(1'b0, 1'b1);
    count_busy(0, n);
    chk("scroll_cycles", n, 80);
    chk("scroll_base_1", int'(scroll_base), 1);
    for (int c = 0; c < 80; c++) rd(0, c, 8'h31);
    for (int c = 0; c < 80; c++) rd(58, c, 8'h6B);
    for (int c = 0; c < 80; c++) rd(59, c, 8'h20);

    for (int k = 2; k <= 60; k++) begin
      pulse(1'b0, 1'b1);
      count_busy(0, n);
      chk("scroll_base_step", int'(scroll_base), k % 60);
    end
    chk("scroll_last_cycles", n, 80);
    sweep_blank();

    pulse(1'b0, 1'b1);
    count_busy(0, n);
    chk("pre_both_base", int'(scroll_base), 1);
    wr(3, 3, 8'h44, w);
    pulse(1'b1, 1'b1);
    count_busy(50, n);
    chk("both_req_clear_cycles", n, 4800);
    chk("both_req_base", int'(scroll_base), 0);
    rd(3, 3, 8'h20);
    rd(2, 3, 8'h20);

    pulse(1'b1, 1'b0);
    chk("stall_wr_ready", int'(wr_ready), 0);
    chk("stall_busy", int'(busy), 1);
    wr(2, 3, 8'h66, w);
    chk("stall_wait_cycles", w, 4800);
    rd(2, 3, 8'h66);
    rd(2, 4, 8'h20);

    pulse(1'b1, 1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_clear_busy", int'(busy), 1);
    chk("rst_clear_wr_ready", int'(wr_ready), 0);
    chk("rst_clear_rd_data", int'(rd_data), 8'h20);
    rst_n = 1'b1;
    count_busy(0, n);
    chk("rst_clear_cycles", n, 4800);
    chk("rst_clear_base", int'(scroll_base), 0);

    wr(5, 5, 8'h99, w);
    rd(5, 5, 8'h99);
    pulse(1'b0, 1'b1);
    repeat (40) @(negedge clk);
    chk("mid_scroll_busy", int'(busy), 1);
    chk("mid_scroll_base", int'(scroll_base), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_scroll_base", int'(scroll_base), 0);
    chk("rst_scroll_busy", int'(busy), 1);
    rst_n = 1'b1;
    count_busy(0, n);
    chk("rst_scroll_cycles", n, 4800);
    chk("rst_scroll_base_after", int'(scroll_base), 0);
    rd(4, 5, 8'h20);
    rd(5, 5, 8'h20);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_text_buffer.md
# vga_text_buffer

Writable, scrollable character buffer for the VGA text display, replacing fixed per-row background strings. Holds a COLS x ROWS grid of CHAR_W-bit character codes, served to the pixel pipeline through a registered read port, and updated by the processor-visualisation logic through a valid/ready write port. A hardware clear engine and single-row hardware scroll are built in. Sits between the visualisation writers and the character lookup stage.

## Interface
- COLS, 80, characters per row
- ROWS, 60, character rows
- CHAR_W, 8, bits per character code
- FILL_CHAR, 8'h20, code written by clear/scroll and returned for out-of-range reads
- ROW_W, 7, row index width (must satisfy 2^ROW_W >= ROWS)
- COL_W, 7, column index width (must satisfy 2^COL_W >= COLS)

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_row  in  ROW_W  logical row to read
- rd_col  in  COL_W  column to read
- rd_data  out  CHAR_W  character at (rd_row, rd_col) sampled the previous cycle
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_row  in  ROW_W  logical row to write
- wr_col  in  COL_W  column to write
- wr_data  in  CHAR_W  character to write
- clear_req  in  1  single-cycle pulse: fill whole screen with FILL_CHAR, reset scroll
- scroll_req  in  1  single-cycle pulse: scroll up one row, blank new bottom row
- busy  out  1  clear or scroll engine active
- scroll_base  out  ROW_W  physical row currently shown as logical row 0

## Operation
- Physical row = (logical row + scroll_base) mod ROWS; address = phys_row*COLS + col, width $clog2(ROWS*COLS). Mod done by single conditional subtract (both operands < ROWS).
- States: CLEAR, IDLE, SCROLL.
- Reset: state=CLEAR, sweep counter=0, scroll_base=0, busy=1, wr_ready=0, rd_data=FILL_CHAR. RAM contents not reset; CLEAR overwrites them.
- CLEAR: writes FILL_CHAR to physical address 0..ROWS*COLS-1, one per cycle; on last address -> IDLE.
- IDLE: wr_ready=1, busy=0. clear_req -> CLEAR, scroll_base<=0. Else scroll_req -> SCROLL, scroll_base<=(scroll_base+1) mod ROWS, engine blanks physical row equal to old scroll_base (new bottom logical row).
- SCROLL: writes FILL_CHAR to COLS addresses of that row, one per cycle; then -> IDLE.
- clear_req and scroll_req together in IDLE: clear wins, scroll dropped. Any request while busy is dropped (no queueing).
- wr_ready = (state==IDLE), combinational from state only. Write accepted in same cycle as clear_req/scroll_req is committed first; engine starts next cycle and may overwrite it.
- Out-of-range write (row>=ROWS or col>=COLS): accepted, discarded. Out-of-range read: rd_data=FILL_CHAR.
- Reads served in every state, including during CLEAR/SCROLL.

## Timing
- Read latency exactly 1 cycle. Read and write same address same cycle: rd_data returns old contents (read-first).
- Accepted write visible to a read issued the following cycle.
- CLEAR: busy high ROWS*COLS cycles (4800 default); busy low and wr_ready high the cycle after the final fill write.
- SCROLL: busy high COLS cycles (80 default); scroll_base updates the cycle after scroll_req, so logical mapping shifts immediately while old bottom data is still being blanked.
- scroll_base wraps ROWS-1 -> 0.
- rst_n asserted mid-CLEAR/SCROLL: immediate return to reset state; full CLEAR restarts after release.

## Structure
- Package vga_text_pkg: state enum (CLEAR, IDLE, SCROLL), default FILL_CHAR, address-width helper function.
- Sub-module vga_text_dpram: simple dual-port RAM, one sync write port, one sync read-first read port, DEPTH and WIDTH parameters; infers block RAM. Write mux (user vs engine) and address arithmetic live in the top.

## Test plan
- Release reset, hold rd_row/rd_col=0..; busy high exactly 4800 cycles, every location then reads 8'h20, scroll_base=0.
- After clear, write 8'h41 to (0,0) and 8'h5A to (59,79); read back next cycle -> 8'h41, 8'h5A; read (60,0) and (0,80) -> 8'h20.
- Fill row r with code r+8'h30, pulse scroll_req: busy 80 cycles, scroll_base=1, logical row 0 reads 8'h31, logical row 59 reads 8'h20.
- 60 scroll pulses (waiting on busy): scroll_base returns to 0, whole screen 8'h20.
- clear_req and scroll_req same IDLE cycle -> CLEAR only, scroll_base=0; scroll_req while busy ignored; wr_valid during busy stalls (wr_ready=0) and commits once IDLE.
- rst_n pulsed 100 cycles into a CLEAR and mid-SCROLL: busy stays high, full 4800-cycle clear repeats, scroll_base=0.
